// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: discards settling words after arm, then forwards a fixed-length
// framed burst through a one-deep output register. The ADC cannot stall, so backpressure drops words.
module adc_capture_ctrl #(
  parameter int SAMP_PER_CLK = 2,
  parameter int CNT_W        = 16,
  parameter int SAMP_W       = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               arm,
  input  logic                               abort,
  input  logic [CNT_W-1:0]                   skip_words,
  input  logic [CNT_W-1:0]                   capture_words,
  input  logic [2*SAMP_W*SAMP_PER_CLK-1:0]   s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic [2*SAMP_W*SAMP_PER_CLK-1:0]   m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tuser,
  output logic                               m_axis_tlast,
  output logic                               busy,
  output logic                               done,
  output logic                               overflow,
  output logic [CNT_W-1:0]                   words_captured
);

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    CAPTURE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] skip_len;
  logic [CNT_W-1:0] cap_len;
  logic [CNT_W-1:0] skip_cnt;
  logic [CNT_W-1:0] load_cnt;
  logic             arm_ok;
  logic             load;
  logic             drop;
  logic             hs;
  logic             room;

  assign s_axis_tready = 1'b1;
  assign hs            = m_axis_tvalid & m_axis_tready;
  assign room          = load_cnt < cap_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Abort takes priority over arm and suppresses any load or drop in its cycle.
  always_comb begin
    state_next = state;
    arm_ok     = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (arm && !abort) begin
          arm_ok = 1'b1;
          if (capture_words == '0) begin
            state_next = DONE;
          end else if (skip_words == '0) begin
            state_next = CAPTURE;
          end else begin
            state_next = SKIP;
          end
        end
      end
      SKIP: begin
        if (s_axis_tvalid && ((skip_cnt + CNT_W'(1)) == skip_len)) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!abort && s_axis_tvalid && room) begin
          if (!m_axis_tvalid || m_axis_tready) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
        if (hs && m_axis_tlast) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_len       <= '0;
      cap_len        <= '0;
      skip_cnt       <= '0;
      load_cnt       <= '0;
      overflow       <= 1'b0;
      words_captured <= '0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tuser   <= 1'b0;
      m_axis_tlast   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      if (arm_ok) begin
        skip_len       <= skip_words;
        cap_len        <= capture_words;
        skip_cnt       <= '0;
        load_cnt       <= '0;
        overflow       <= 1'b0;
        words_captured <= '0;
      end
      if (state == SKIP && s_axis_tvalid) begin
        skip_cnt <= skip_cnt + CNT_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      // A handshake on the bus counts even if abort lands in the same cycle.
      if (hs) begin
        words_captured <= words_captured + CNT_W'(1);
      end
      if (load) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tuser <= (load_cnt == '0);
        m_axis_tlast <= (load_cnt == (cap_len - CNT_W'(1)));
        load_cnt     <= load_cnt + CNT_W'(1);
      end else if (abort || hs) begin
        m_axis_tuser <= 1'b0;
        m_axis_tlast <= 1'b0;
      end
      if (abort) begin
        m_axis_tvalid <= 1'b0;
      end else if (load) begin
        m_axis_tvalid <= 1'b1;
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
      end
      busy <= (state_next == SKIP) || (state_next == CAPTURE);
      done <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: a scoreboard of expected framed words is filled
// as each capture is armed and drained by a monitor on every m_axis handshake.
module tb_adc_capture_ctrl;

  localparam int CNT_W  = 16;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              arm;
  logic              abort;
  logic [CNT_W-1:0]  skip_words;
  logic [CNT_W-1:0]  capture_words;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tuser;
  logic              m_axis_tlast;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [CNT_W-1:0]  words_captured;

  int vectorCount = 0;
  int missCount   = 0;
  int seqNum      = 0;
  int armSeq      = 0;
  logic [DATA_W+1:0] sb[$];

  adc_capture_ctrl #(.SAMP_PER_CLK(2), .CNT_W(CNT_W), .SAMP_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .abort(abort),
    .skip_words(skip_words),
    .capture_words(capture_words),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .words_captured(words_captured)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mk(input int s);
    return 64'h5A00_3C00_0000_0000 | DATA_W'(s);
  endfunction

  task automatic checkOutput(input string tag, input logic [DATA_W+1:0] observed,
                             input logic [DATA_W+1:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Word k counts from the arm cycle: k=1 is the first word after arm.
  task automatic expectWord(input int k, input logic u, input logic l);
    sb.push_back({u, l, mk(armSeq + k)});
  endtask

  // One clock of stimulus; the ADC word changes every cycle whether or not it is valid.
  task automatic applyStimulus(input logic a, input logic ab, input logic v, input logic r);
    arm           = a;
    abort         = ab;
    s_axis_tvalid = v;
    m_axis_tready = r;
    s_axis_tdata  = mk(seqNum);
    @(posedge clk);
    #1;
    seqNum++;
    arm   = 1'b0;
    abort = 1'b0;
  endtask

  task automatic runUntilDone(input string tag);
    int n = 0;
    while (!done && n < 40) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      n++;
    end
    checkOutput(tag, (DATA_W+2)'(done), (DATA_W+2)'(1));
  endtask

  // Every delivered word must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      checkOutput("sb_pending", (DATA_W+2)'(sb.size() != 0), (DATA_W+2)'(1));
      if (sb.size() != 0) begin
        checkOutput("sb_word", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, sb.pop_front());
      end
    end
  end

  initial begin
    rst           = 1'b1;
    arm           = 1'b0;
    abort         = 1'b0;
    skip_words    = '0;
    capture_words = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_outputs",
                {m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy, done, overflow, 58'(words_captured)},
                '0);
    checkOutput("rst_tdata", m_axis_tdata, '0);

    // Nominal: skip 3, capture 8, continuous input.
    skip_words = 3; capture_words = 8; armSeq = seqNum;
    for (int k = 4; k <= 11; k++) expectWord(k, k == 4, k == 11);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    skip_words = 7; capture_words = 7;
    checkOutput("nom_busy", busy, 1);
    repeat (11) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("nom_last_on_bus", {m_axis_tvalid, m_axis_tlast, done}, 3'b110);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("nom_done", {done, busy, m_axis_tvalid, overflow}, 4'b1000);
    checkOutput("nom_count", words_captured, 8);

    // Zero skip: first post-arm word forwarded with tuser.
    skip_words = 0; capture_words = 4; armSeq = seqNum;
    for (int k = 1; k <= 4; k++) expectWord(k, k == 1, k == 4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("zskip_busy", {busy, done}, 2'b10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("zskip_first", {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, {2'b11, mk(armSeq + 1)});
    runUntilDone("zskip_done");
    checkOutput("zskip_count", words_captured, 4);

    // Zero capture: abort to IDLE first so done visibly rises.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("zcap_idle", {done, busy}, 2'b00);
    skip_words = 5; capture_words = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("zcap_done", {done, busy}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("zcap_no_valid", m_axis_tvalid, 0);
    end
    checkOutput("zcap_count", words_captured, 0);

    // Backpressure: two stalled cycles drop words 3 and 4.
    skip_words = 0; capture_words = 6; armSeq = seqNum;
    expectWord(1, 1'b1, 1'b0);
    expectWord(2, 1'b0, 1'b0);
    expectWord(5, 1'b0, 1'b0);
    expectWord(6, 1'b0, 1'b0);
    expectWord(7, 1'b0, 1'b0);
    expectWord(8, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("bp_ovf_low", overflow, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_ovf_rise", overflow, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runUntilDone("bp_done");
    checkOutput("bp_status", {overflow, 16'(words_captured)}, {1'b1, 16'd6});

    // Rearm from DONE clears status and runs a 5-word capture.
    skip_words = 2; capture_words = 5; armSeq = seqNum;
    for (int k = 3; k <= 7; k++) expectWord(k, k == 3, k == 7);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("rearm_clear", {done, overflow, busy, 16'(words_captured)}, {3'b001, 16'd0});
    runUntilDone("rearm_done");
    checkOutput("rearm_count", words_captured, 5);

    // Abort after three handshakes of a 10-word capture.
    skip_words = 0; capture_words = 10; armSeq = seqNum;
    for (int k = 1; k <= 3; k++) expectWord(k, k == 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("abort_state", {m_axis_tvalid, busy, done, overflow}, 4'b0000);
    checkOutput("abort_count", words_captured, 3);
    skip_words = 1; capture_words = 2; armSeq = seqNum;
    expectWord(2, 1'b1, 1'b0);
    expectWord(3, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    runUntilDone("abort_rearm_done");
    checkOutput("abort_rearm_count", words_captured, 2);

    // Arm while skipping must not relatch the lengths.
    skip_words = 4; capture_words = 3; armSeq = seqNum;
    for (int k = 5; k <= 7; k++) expectWord(k, k == 5, k == 7);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    skip_words = 0; capture_words = 1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("busyarm_still_busy", {busy, m_axis_tvalid}, 2'b10);
    runUntilDone("busyarm_done");
    checkOutput("busyarm_count", words_captured, 3);

    // Reset in the middle of a capture.
    skip_words = 0; capture_words = 10; armSeq = seqNum;
    expectWord(1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("midrst_pre", {m_axis_tvalid, busy, 16'(words_captured)}, {2'b11, 16'd1});
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("midrst_outputs",
                {m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy, done, overflow, 58'(words_captured)},
                '0);
    checkOutput("midrst_tdata", m_axis_tdata, '0);

    checkOutput("sb_drained", (DATA_W+2)'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
